// File: rtl/td4_cpu.sv
// TD4 4-bit processor core: registers A, B, OUT, PC and carry, executing one
// instruction from an external 16x8 ROM every CLK_DIV system clocks.
module td4_cpu #(
   parameter logic [31:0] CLK_DIV = 32'd16000000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] rom_addr,
   input  logic [7:0] rom_data,
   input  logic [3:0] in_port,
   output logic [3:0] out_port,
   output logic       carry,
   output logic       step
);

   typedef enum logic [3:0] {
      OP_ADD_A  = 4'b0000,
      OP_MOV_AB = 4'b0001,
      OP_IN_A   = 4'b0010,
      OP_MOV_AI = 4'b0011,
      OP_MOV_BA = 4'b0100,
      OP_ADD_B  = 4'b0101,
      OP_IN_B   = 4'b0110,
      OP_MOV_BI = 4'b0111,
      OP_NOP_8  = 4'b1000,
      OP_OUT_B  = 4'b1001,
      OP_NOP_A  = 4'b1010,
      OP_OUT_I  = 4'b1011,
      OP_NOP_C  = 4'b1100,
      OP_NOP_D  = 4'b1101,
      OP_JNC    = 4'b1110,
      OP_JMP    = 4'b1111
   } opcode_t;

   localparam logic [31:0] DIV_LAST = CLK_DIV - 32'd1;

   logic [31:0] div;
   logic [3:0]  a, b, out_r, pc;
   logic        c;

   logic [3:0]  a_next, b_next, out_next, pc_next;
   logic        c_next;
   logic [3:0]  alu_x;
   logic [4:0]  sum;
   opcode_t     op;
   logic [3:0]  im;

   assign op       = opcode_t'(rom_data[7:4]);
   assign im       = rom_data[3:0];
   assign rom_addr = pc;
   assign out_port = out_r;
   assign carry    = c;
   // Gated by reset so step stays low while reset is held, even with CLK_DIV=1.
   assign step     = ~reset & (div == DIV_LAST);

   assign alu_x = (op == OP_ADD_B) ? b : a;
   assign sum   = {1'b0, alu_x} + {1'b0, im};

   always_comb begin
      a_next   = a;
      b_next   = b;
      out_next = out_r;
      c_next   = 1'b0;
      pc_next  = pc + 4'd1;
      case (op)
         OP_ADD_A:  begin a_next = sum[3:0]; c_next = sum[4]; end
         OP_MOV_AB: a_next = b;
         OP_IN_A:   a_next = in_port;
         OP_MOV_AI: a_next = im;
         OP_MOV_BA: b_next = a;
         OP_ADD_B:  begin b_next = sum[3:0]; c_next = sum[4]; end
         OP_IN_B:   b_next = in_port;
         OP_MOV_BI: b_next = im;
         OP_OUT_B:  out_next = b;
         OP_OUT_I:  out_next = im;
         OP_JNC:    if (!c) pc_next = im;
         OP_JMP:    pc_next = im;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div   <= '0;
         a     <= '0;
         b     <= '0;
         out_r <= '0;
         pc    <= '0;
         c     <= 1'b0;
      end else begin
         if (step) div <= '0;
         else      div <= div + 32'd1;
         if (step) begin
            a     <= a_next;
            b     <= b_next;
            out_r <= out_next;
            pc    <= pc_next;
            c     <= c_next;
         end
      end
   end

endmodule

// File: tb/tb_td4_cpu.sv
// Directed bench for td4_cpu: prescaler timing with CLK_DIV=4 and small
// programs on a CLK_DIV=1 core, checking rom_addr, out_port and carry.
module tb_td4_cpu;

   logic       clk;
   logic       reset;
   logic [7:0] rom [16];
   logic [3:0] in_port;

   logic [3:0] rom_addr1, out_port1;
   logic [7:0] rom_data1;
   logic       carry1, step1;

   logic [3:0] rom_addr4, out_port4;
   logic [7:0] rom_data4;
   logic       carry4, step4;

   int unsigned total;
   int unsigned bad;

   assign rom_data1 = rom[rom_addr1];
   assign rom_data4 = rom[rom_addr4];

   td4_cpu #(.CLK_DIV(32'd1)) dut (
      .clk(clk), .reset(reset), .rom_addr(rom_addr1), .rom_data(rom_data1),
      .in_port(in_port), .out_port(out_port1), .carry(carry1), .step(step1)
   );

   td4_cpu #(.CLK_DIV(32'd4)) dut4 (
      .clk(clk), .reset(reset), .rom_addr(rom_addr4), .rom_data(rom_data4),
      .in_port(in_port), .out_port(out_port4), .carry(carry4), .step(step4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_rom(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   task automatic exec(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Hold reset, check cleared outputs, release at a falling edge.
   task automatic restart();
      reset = 1'b1;
      @(negedge clk);
      check("rst_addr", rom_addr1, 0);
      check("rst_out", out_port1, 0);
      check("rst_carry", carry1, 0);
      check("rst_step", step1, 0);
      reset = 1'b0;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset   = 1'b1;
      in_port = 4'h0;
      fill_rom(8'h80);

      // Prescaler with CLK_DIV=4
      exec(2);
      check("p_rst_addr", rom_addr4, 0);
      check("p_rst_out", out_port4, 0);
      check("p_rst_carry", carry4, 0);
      check("p_rst_step", step4, 0);
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         check($sformatf("p_step%0d", k), step4, (k % 4 == 0) ? 1 : 0);
         exec(1);
         check($sformatf("p_pc%0d", k), rom_addr4, k / 4);
      end
      check("p_out", out_port4, 0);
      check("p_carry", carry4, 0);

      // Blink: OUT F, OUT 0, JMP 0
      reset = 1'b1;
      fill_rom(8'h80);
      rom[0] = 8'hBF; rom[1] = 8'hB0; rom[2] = 8'hF0;
      restart();
      for (int r = 0; r < 2; r++) begin
         exec(1);
         check("bl_out1", out_port1, 4'hF);
         check("bl_pc1", rom_addr1, 1);
         exec(1);
         check("bl_out2", out_port1, 4'h0);
         check("bl_pc2", rom_addr1, 2);
         exec(1);
         check("bl_out3", out_port1, 4'h0);
         check("bl_pc3", rom_addr1, 0);
      end
      exec(1);
      check("bl_pre_rst", out_port1, 4'hF);
      #2 reset = 1'b1;
      #1;
      check("bl_async_out", out_port1, 0);
      check("bl_async_pc", rom_addr1, 0);

      // ADD carry then JNC not taken
      fill_rom(8'h80);
      rom[0] = 8'h39; rom[1] = 8'h08; rom[2] = 8'hE0; rom[3] = 8'hB7;
      restart();
      exec(2);
      check("add_carry", carry1, 1);
      exec(1);
      check("jnc_nt_pc", rom_addr1, 3);
      check("jnc_nt_carry", carry1, 0);
      exec(1);
      check("add_out", out_port1, 4'h7);

      // JNC taken
      reset = 1'b1;
      fill_rom(8'h80);
      rom[0] = 8'h31; rom[1] = 8'h01; rom[2] = 8'hE5; rom[5] = 8'hB9;
      restart();
      exec(2);
      check("jt_carry", carry1, 0);
      exec(1);
      check("jt_pc", rom_addr1, 5);
      exec(1);
      check("jt_out", out_port1, 4'h9);

      // Moves and IN
      reset = 1'b1;
      fill_rom(8'h80);
      rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h73; rom[3] = 8'h10;
      rom[4] = 8'h90; rom[5] = 8'h60; rom[6] = 8'h90;
      in_port = 4'hA;
      restart();
      exec(5);
      check("mv_out3", out_port1, 4'h3);
      in_port = 4'h5;
      exec(2);
      check("mv_out5", out_port1, 4'h5);

      // IN A, MOV B,A, OUT B carries the switch value through A
      reset = 1'b1;
      fill_rom(8'h80);
      rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h90;
      in_port = 4'hC;
      restart();
      exec(3);
      check("in_a_out", out_port1, 4'hC);

      // ADD B with carry, OUT B, other NOP encodings
      reset = 1'b1;
      fill_rom(8'h80);
      rom[0] = 8'h75; rom[1] = 8'h5C; rom[2] = 8'h90;
      rom[3] = 8'hA0; rom[4] = 8'hC0; rom[5] = 8'hD0;
      restart();
      exec(2);
      check("addb_carry", carry1, 1);
      exec(1);
      check("addb_out", out_port1, 4'h1);
      check("outb_carry", carry1, 0);
      exec(3);
      check("nops_pc", rom_addr1, 6);
      check("nops_out", out_port1, 4'h1);

      // PC wrap through all-NOP ROM
      reset = 1'b1;
      fill_rom(8'h80);
      restart();
      for (int k = 1; k <= 17; k++) begin
         exec(1);
         check($sformatf("wrap_pc%0d", k), rom_addr1, k % 16);
      end
      check("wrap_out", out_port1, 0);
      check("wrap_carry", carry1, 0);

      // NOP clears a preloaded carry
      reset = 1'b1;
      fill_rom(8'h80);
      rom[0] = 8'h3F; rom[1] = 8'h01;
      restart();
      exec(2);
      check("nop_pre_carry", carry1, 1);
      exec(1);
      check("nop_carry", carry1, 0);
      check("nop_pc", rom_addr1, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
